// File: rtl/sim_bus_pkg.sv
// ============================================================================
// Module   : sim_bus_pkg
// Purpose  : Shared types and helpers for the simulation bus arbiter.
//            Holds the host-ID width helper and default-width request /
//            response bundles used when describing a single bus beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_bus_pkg;

  // Default bus geometry for the bundle typedefs below.
  localparam int c_BUS_AW = 32;
  localparam int c_BUS_DW = 32;

  // Width of a host index; a lone bit is kept even for NrHosts <= 2 so the
  // ID FIFO never collapses to zero width.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                    we;
    logic [c_BUS_AW-1:0]     addr;
    logic [c_BUS_DW-1:0]     wdata;
    logic [c_BUS_DW/8-1:0]   be;
  } bus_req_t;

  typedef struct packed {
    logic [c_BUS_DW-1:0]     rdata;
    logic                    err;
  } bus_rsp_t;

endpackage

`default_nettype wire

// File: rtl/sim_bus_id_fifo.sv
// ============================================================================
// Module   : sim_bus_id_fifo
// Purpose  : Small synchronous FIFO holding the host index of every granted,
//            not-yet-answered transaction, so responses can be routed back.
// Ports    : clk_i, rst_ni (async, active-low)
//            push / wdata  - enqueue a host index
//            pop  / rdata  - dequeue; rdata shows the current head
//            full / empty  - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_bus_id_fifo #(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int c_CNT_W = $clog2(Depth + 1);

  logic [Width-1:0]   r_mem [Depth];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full   = (r_count == c_CNT_W'(Depth));
  assign empty  = (r_count == '0);
  assign rdata  = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr <= (r_wptr == c_PTR_W'(Depth - 1)) ? '0 : r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_PTR_W'(Depth - 1)) ? '0 : r_rptr + c_PTR_W'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sim_bus_arbiter.sv
// ============================================================================
// Module   : sim_bus_arbiter
// Purpose  : Simulation-only N-host to 1-device round-robin arbiter sharing a
//            RAM data port. Uses req/gnt/rvalid on every side, locks a stalled
//            request onto the device, and routes in-order responses back via
//            an outstanding-ID FIFO.
// Ports    : clk_i, rst_ni (async, active-low)
//            host_*_i / host_*_o - packed per-host request and response lanes
//            dev_*_o / dev_*_i   - single device port
//            unexpected_rsp_o    - sticky: response seen with nothing pending
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_bus_arbiter
  import sim_bus_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrHosts-1:0]               host_req_i,
  input  logic [NrHosts-1:0]               host_we_i,
  input  logic [NrHosts*AddrWidth-1:0]     host_addr_i,
  input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
  input  logic [NrHosts*DataWidth/8-1:0]   host_be_i,
  output logic [NrHosts-1:0]               host_gnt_o,
  output logic [NrHosts-1:0]               host_rvalid_o,
  output logic [DataWidth-1:0]             host_rdata_o,
  output logic [NrHosts-1:0]               host_err_o,
  output logic                             dev_req_o,
  output logic                             dev_we_o,
  output logic [AddrWidth-1:0]             dev_addr_o,
  output logic [DataWidth-1:0]             dev_wdata_o,
  output logic [DataWidth/8-1:0]           dev_be_o,
  input  logic                             dev_gnt_i,
  input  logic                             dev_rvalid_i,
  input  logic [DataWidth-1:0]             dev_rdata_i,
  input  logic                             dev_err_i,
  output logic                             unexpected_rsp_o
);

  localparam int c_ID_W = id_width(NrHosts);
  localparam int c_BE_W = DataWidth / 8;

  logic [c_ID_W-1:0] r_rr_ptr;
  logic              r_lock;
  logic [c_ID_W-1:0] r_lock_id;
  logic              r_unexp;

  logic [c_ID_W-1:0] w_arb_id;
  logic              w_arb_found;
  logic [c_ID_W-1:0] w_winner;
  logic [c_ID_W-1:0] w_ptr_nxt;
  logic [c_ID_W-1:0] w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_grant;
  logic              w_pop;

  // --------------------------------------------------------------------------
  // Round-robin search: first requester at or after the pointer, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    w_arb_id    = '0;
    w_arb_found = 1'b0;
    for (int i = 0; i < NrHosts; i++) begin
      if (!w_arb_found && host_req_i[(int'(r_rr_ptr) + i) % NrHosts]) begin
        w_arb_found = 1'b1;
        w_arb_id    = c_ID_W'((int'(r_rr_ptr) + i) % NrHosts);
      end
    end
  end

  // A stalled request owns the device until granted, so later arrivals
  // cannot disturb the address/data the device is already looking at.
  assign w_winner  = r_lock ? r_lock_id : w_arb_id;
  assign w_ptr_nxt = (w_winner == c_ID_W'(NrHosts - 1)) ? '0 : w_winner + c_ID_W'(1);

  // Full blocks requests even when a pop lands in the same cycle; this keeps
  // dev_req_o off the response path at the cost of a one-cycle bubble.
  assign dev_req_o = ((|host_req_i) | r_lock) & ~w_fifo_full;
  assign w_grant   = dev_req_o & dev_gnt_i;
  assign w_pop     = dev_rvalid_i & ~w_fifo_empty;

  // --------------------------------------------------------------------------
  // Device-side request mux and per-host grant / response demux.
  // --------------------------------------------------------------------------
  always_comb begin
    dev_we_o      = 1'b0;
    dev_addr_o    = '0;
    dev_wdata_o   = '0;
    dev_be_o      = '0;
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (w_winner == c_ID_W'(h)) begin
        dev_we_o    = host_we_i[h];
        dev_addr_o  = host_addr_i[h*AddrWidth +: AddrWidth];
        dev_wdata_o = host_wdata_i[h*DataWidth +: DataWidth];
        dev_be_o    = host_be_i[h*c_BE_W +: c_BE_W];
        host_gnt_o[h] = w_grant;
      end
      if (w_head == c_ID_W'(h)) begin
        host_rvalid_o[h] = w_pop;
        host_err_o[h]    = w_pop & dev_err_i;
      end
    end
  end

  assign host_rdata_o     = dev_rdata_i;
  assign unexpected_rsp_o = r_unexp;

  // --------------------------------------------------------------------------
  // Pointer, lock and sticky unexpected-response state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_unexp   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_ptr_nxt;
        r_lock   <= 1'b0;
      end else if (dev_req_o) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_winner;
      end
      if (dev_rvalid_i && w_fifo_empty) begin
        r_unexp <= 1'b1;
      end
    end
  end

  sim_bus_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (c_ID_W)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (w_grant),
    .pop   (w_pop),
    .wdata (w_winner),
    .rdata (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

`ifndef SYNTHESIS
  // --------------------------------------------------------------------------
  // Protocol checks on the host side: a pending request must hold its
  // request line and its fields until granted.
  // --------------------------------------------------------------------------
  for (genvar h = 0; h < NrHosts; h++) begin : g_host_chk
    logic                 r_pend;
    logic                 r_we;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [c_BE_W-1:0]    r_be;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pend  <= 1'b0;
        r_we    <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_be    <= '0;
      end else begin
        if (r_pend) begin
          assert (host_req_i[h])
            else $error("sim_bus_arbiter: host %0d dropped req before gnt", h);
          assert (host_we_i[h] == r_we &&
                  host_addr_i[h*AddrWidth +: AddrWidth] == r_addr &&
                  host_wdata_i[h*DataWidth +: DataWidth] == r_wdata &&
                  host_be_i[h*c_BE_W +: c_BE_W] == r_be)
            else $error("sim_bus_arbiter: host %0d changed fields while waiting", h);
        end
        r_pend  <= host_req_i[h] & ~host_gnt_o[h];
        r_we    <= host_we_i[h];
        r_addr  <= host_addr_i[h*AddrWidth +: AddrWidth];
        r_wdata <= host_wdata_i[h*DataWidth +: DataWidth];
        r_be    <= host_be_i[h*c_BE_W +: c_BE_W];
      end
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(dev_rvalid_i && w_fifo_empty && dev_gnt_i))
        else $error("sim_bus_arbiter: response in the same cycle as its grant");
      assert (!(dev_rvalid_i && w_fifo_empty))
        else $warning("sim_bus_arbiter: response with no outstanding transaction");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sim_bus_arbiter.sv
// ============================================================================
// Module   : tb_sim_bus_arbiter
// Purpose  : Directed self-checking bench for sim_bus_arbiter (2 hosts,
//            2 outstanding, 32-bit address/data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_bus_arbiter;

  localparam int c_NH = 2;
  localparam int c_AW = 32;
  localparam int c_DW = 32;
  localparam int c_BW = c_DW / 8;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [c_NH-1:0]          host_req_i = '0;
  logic [c_NH-1:0]          host_we_i = '0;
  logic [c_NH*c_AW-1:0]     host_addr_i = '0;
  logic [c_NH*c_DW-1:0]     host_wdata_i = '0;
  logic [c_NH*c_BW-1:0]     host_be_i = '0;
  logic [c_NH-1:0]          host_gnt_o;
  logic [c_NH-1:0]          host_rvalid_o;
  logic [c_DW-1:0]          host_rdata_o;
  logic [c_NH-1:0]          host_err_o;
  logic                     dev_req_o;
  logic                     dev_we_o;
  logic [c_AW-1:0]          dev_addr_o;
  logic [c_DW-1:0]          dev_wdata_o;
  logic [c_BW-1:0]          dev_be_o;
  logic                     dev_gnt_i = 1'b0;
  logic                     dev_rvalid_i = 1'b0;
  logic [c_DW-1:0]          dev_rdata_i = '0;
  logic                     dev_err_i = 1'b0;
  logic                     unexpected_rsp_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  sim_bus_arbiter #(
    .NrHosts       (c_NH),
    .MaxOutstanding(2),
    .AddrWidth     (c_AW),
    .DataWidth     (c_DW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .host_req_i      (host_req_i),
    .host_we_i       (host_we_i),
    .host_addr_i     (host_addr_i),
    .host_wdata_i    (host_wdata_i),
    .host_be_i       (host_be_i),
    .host_gnt_o      (host_gnt_o),
    .host_rvalid_o   (host_rvalid_o),
    .host_rdata_o    (host_rdata_o),
    .host_err_o      (host_err_o),
    .dev_req_o       (dev_req_o),
    .dev_we_o        (dev_we_o),
    .dev_addr_o      (dev_addr_o),
    .dev_wdata_o     (dev_wdata_o),
    .dev_be_o        (dev_be_o),
    .dev_gnt_i       (dev_gnt_i),
    .dev_rvalid_i    (dev_rvalid_i),
    .dev_rdata_i     (dev_rdata_i),
    .dev_err_i       (dev_err_i),
    .unexpected_rsp_o(unexpected_rsp_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 units later.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
    host_req_i   = req;
    dev_gnt_i    = gnt;
    dev_rvalid_i = rv;
    dev_rdata_i  = rdata;
    dev_err_i    = err;
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) next_cycle();
    settle();
    chk("rst_gnt",    64'(host_gnt_o),       64'h0);
    chk("rst_rvalid", 64'(host_rvalid_o),    64'h0);
    chk("rst_err",    64'(host_err_o),       64'h0);
    chk("rst_devreq", 64'(dev_req_o),        64'h0);
    chk("rst_unexp",  64'(unexpected_rsp_o), 64'h0);
    rst_ni = 1'b1;
    next_cycle();

    // ---------------- single host read ----------------
    host_addr_i[31:0] = 32'h100;
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("t1_devreq", 64'(dev_req_o),  64'h1);
    chk("t1_gnt",    64'(host_gnt_o), 64'h1);
    chk("t1_addr",   64'(dev_addr_o), 64'h100);
    chk("t1_we",     64'(dev_we_o),   64'h0);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    settle();
    chk("t1_rvalid", 64'(host_rvalid_o), 64'h1);
    chk("t1_rdata",  64'(host_rdata_o),  64'hDEADBEEF);
    chk("t1_err",    64'(host_err_o),    64'h0);
    chk("t1_idle",   64'(dev_req_o),     64'h0);
    next_cycle();

    // ---------------- contention (pointer now 1) ----------------
    host_addr_i[31:0]  = 32'h400;
    host_addr_i[63:32] = 32'h300;
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("c1_gnt",  64'(host_gnt_o), 64'h2);
    chk("c1_addr", 64'(dev_addr_o), 64'h300);
    next_cycle();
    drive(2'b11, 1'b1, 1'b1, 32'h11, 1'b0);
    settle();
    chk("c2_gnt",    64'(host_gnt_o),    64'h1);
    chk("c2_addr",   64'(dev_addr_o),    64'h400);
    chk("c2_rvalid", 64'(host_rvalid_o), 64'h2);
    next_cycle();
    drive(2'b11, 1'b1, 1'b1, 32'h22, 1'b0);
    settle();
    chk("c3_gnt",    64'(host_gnt_o),    64'h2);
    chk("c3_rvalid", 64'(host_rvalid_o), 64'h1);
    next_cycle();
    drive(2'b11, 1'b1, 1'b1, 32'h33, 1'b0);
    settle();
    chk("c4_gnt",    64'(host_gnt_o),    64'h1);
    chk("c4_rvalid", 64'(host_rvalid_o), 64'h2);
    next_cycle();
    drive(2'b10, 1'b1, 1'b1, 32'h44, 1'b0);
    settle();
    chk("c5_gnt",    64'(host_gnt_o),    64'h2);
    chk("c5_rvalid", 64'(host_rvalid_o), 64'h1);
    chk("c5_rdata",  64'(host_rdata_o),  64'h44);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'h55, 1'b0);
    settle();
    chk("c6_rvalid", 64'(host_rvalid_o), 64'h2);
    chk("c6_devreq", 64'(dev_req_o),     64'h0);
    next_cycle();

    // ---------------- stall and lock (pointer now 0) ----------------
    host_addr_i[63:32] = 32'h200;
    drive(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("s1_devreq", 64'(dev_req_o),  64'h1);
    chk("s1_addr",   64'(dev_addr_o), 64'h200);
    chk("s1_gnt",    64'(host_gnt_o), 64'h0);
    next_cycle();
    drive(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("s2_addr", 64'(dev_addr_o), 64'h200);
    chk("s2_gnt",  64'(host_gnt_o), 64'h0);
    next_cycle();
    settle();
    chk("s3_addr", 64'(dev_addr_o), 64'h200);
    next_cycle();
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("s4_addr", 64'(dev_addr_o), 64'h200);
    chk("s4_gnt",  64'(host_gnt_o), 64'h2);
    next_cycle();
    drive(2'b01, 1'b1, 1'b1, 32'hA5, 1'b0);
    settle();
    chk("s5_gnt",    64'(host_gnt_o),    64'h1);
    chk("s5_addr",   64'(dev_addr_o),    64'h400);
    chk("s5_rvalid", 64'(host_rvalid_o), 64'h2);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'hB6, 1'b0);
    settle();
    chk("s6_rvalid", 64'(host_rvalid_o), 64'h1);
    next_cycle();

    // ---------------- FIFO full (pointer now 1) ----------------
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("f1_gnt", 64'(host_gnt_o), 64'h1);
    next_cycle();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("f2_gnt", 64'(host_gnt_o), 64'h2);
    next_cycle();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("f3_devreq", 64'(dev_req_o),  64'h0);
    chk("f3_gnt",    64'(host_gnt_o), 64'h0);
    next_cycle();
    drive(2'b01, 1'b1, 1'b1, 32'hC1, 1'b0);
    settle();
    chk("f4_devreq", 64'(dev_req_o),     64'h0);
    chk("f4_gnt",    64'(host_gnt_o),    64'h0);
    chk("f4_rvalid", 64'(host_rvalid_o), 64'h1);
    next_cycle();
    drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("f5_devreq", 64'(dev_req_o),  64'h1);
    chk("f5_gnt",    64'(host_gnt_o), 64'h1);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'hC2, 1'b0);
    settle();
    chk("f6_rvalid", 64'(host_rvalid_o), 64'h2);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'hC3, 1'b0);
    settle();
    chk("f7_rvalid", 64'(host_rvalid_o), 64'h1);
    next_cycle();

    // ---------------- error routing, host1 write (pointer now 1) ----------------
    host_we_i[1]        = 1'b1;
    host_wdata_i[63:32] = 32'h12345678;
    host_be_i[7:4]      = 4'h3;
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("e1_gnt",   64'(host_gnt_o),  64'h2);
    chk("e1_we",    64'(dev_we_o),    64'h1);
    chk("e1_wdata", 64'(dev_wdata_o), 64'h12345678);
    chk("e1_be",    64'(dev_be_o),    64'h3);
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b1);
    settle();
    chk("e2_rvalid", 64'(host_rvalid_o), 64'h2);
    chk("e2_err",    64'(host_err_o),    64'h2);
    next_cycle();

    // ---------------- spurious response ----------------
    drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
    settle();
    chk("sp_rvalid", 64'(host_rvalid_o),    64'h0);
    chk("sp_unexp0", 64'(unexpected_rsp_o), 64'h0);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("sp_unexp1", 64'(unexpected_rsp_o), 64'h1);
    next_cycle();
    settle();
    chk("sp_sticky", 64'(unexpected_rsp_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    chk("sp_rstclr", 64'(unexpected_rsp_o), 64'h0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();

    // ---------------- reset mid-transaction ----------------
    drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("r1_gnt", 64'(host_gnt_o), 64'h1);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'h77, 1'b0);
    settle();
    chk("r3_rvalid", 64'(host_rvalid_o), 64'h0);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("r4_unexp", 64'(unexpected_rsp_o), 64'h1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
